// File: rtl/mlp_feature_sequencer.sv
// mlp_feature_sequencer
// Input-side sequencer for the combinational MLP classifier. Packs a frame of
// N_FEAT feature beats into the flat classifier input vector, holds it while
// the classifier settles, then captures the class index and offers it on a
// valid/ready result port.
// Optional build macro: MLP_SEQ_DOUBLE_SAMPLE_EN (double-sample settle check;
// a mismatching pair re-runs the settle window once and flags m_fault if the
// second pair also disagrees).
module mlp_feature_sequencer #(
    parameter int N_FEAT     = 8,
    parameter int FEAT_W     = 4,
    parameter int CLS_W      = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_inp,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     m_fault,
    output logic                     err_len
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_FEAT*FEAT_W-1:0]  feat_q, feat_d;
    logic [CLS_W-1:0]          cls_q, cls_d;
    logic                      err_q, err_d;
    logic                      beat_acc;

`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
    logic                      fault_q, fault_d;
    logic                      samp_b_q, samp_b_d;   // next settle-cycle edge takes sample B
    logic                      retry_q, retry_d;     // settle window already re-run once
    logic [CLS_W-1:0]          cls_a_q, cls_a_d;
`endif

    assign beat_acc = s_valid & s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: frame index, settle counter, vector, captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            feat_q <= '0;
            cls_q  <= '0;
            err_q  <= 1'b0;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
            fault_q  <= 1'b0;
            samp_b_q <= 1'b0;
            retry_q  <= 1'b0;
            cls_a_q  <= '0;
`endif
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            feat_q <= feat_d;
            cls_q  <= cls_d;
            err_q  <= err_d;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
            fault_q  <= fault_d;
            samp_b_q <= samp_b_d;
            retry_q  <= retry_d;
            cls_a_q  <= cls_a_d;
`endif
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        feat_d  = feat_q;
        cls_d   = cls_q;
        err_d   = 1'b0;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
        fault_d  = fault_q;
        samp_b_d = samp_b_q;
        retry_d  = retry_q;
        cls_a_d  = cls_a_q;
`endif
        unique case (state_q)
            COLLECT: begin
                if (beat_acc) begin
                    feat_d[idx_q*FEAT_W +: FEAT_W] = s_data;
                    if (idx_q == IDX_LAST) begin
                        // Full frame: used even when s_last is missing
                        idx_d   = '0;
                        cnt_d   = '0;
                        err_d   = ~s_last;
                        state_d = SETTLE;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
                        samp_b_d = 1'b0;
                        retry_d  = 1'b0;
`endif
                    end else if (s_last) begin
                        // Short frame is discarded; partial vector stays visible
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SETTLE: begin
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
                if (samp_b_q) begin
                    samp_b_d = 1'b0;
                    if (cls_in == cls_a_q) begin
                        cls_d   = cls_in;
                        fault_d = 1'b0;
                        state_d = OUTPUT;
                    end else if (retry_q) begin
                        cls_d   = cls_in;
                        fault_d = 1'b1;
                        state_d = OUTPUT;
                    end else begin
                        retry_d = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cls_a_d  = cls_in;
                    samp_b_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (cnt_q == CNT_LAST) begin
                    cls_d   = cls_in;
                    cnt_d   = '0;
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            OUTPUT: begin
                if (m_ready) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output decode
    always_comb begin
        s_ready  = (state_q == COLLECT) && !rst;
        m_valid  = (state_q == OUTPUT);
        feat_inp = feat_q;
        m_class  = cls_q;
        err_len  = err_q;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
        m_fault  = fault_q;
`else
        m_fault  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Directed testbench for mlp_feature_sequencer (default parameters).
// Honours MLP_SEQ_DOUBLE_SAMPLE_EN for latency and fault expectations.
module tb_mlp_feature_sequencer;

    localparam int N_FEAT     = 8;
    localparam int FEAT_W     = 4;
    localparam int CLS_W      = 2;
    localparam int SETTLE_CYC = 4;
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
    localparam int LAT = SETTLE_CYC + 1;
`else
    localparam int LAT = SETTLE_CYC;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic [FEAT_W-1:0]        s_data = '0;
    logic                     s_last = 1'b0;
    logic [N_FEAT*FEAT_W-1:0] feat_inp;
    logic [CLS_W-1:0]         cls_in = '0;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic [CLS_W-1:0]         m_class;
    logic                     m_fault;
    logic                     err_len;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    int n;
    int e0;
    int cnt_mv;

    mlp_feature_sequencer #(
        .N_FEAT    (N_FEAT),
        .FEAT_W    (FEAT_W),
        .CLS_W     (CLS_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .feat_inp(feat_inp),
        .cls_in  (cls_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_class (m_class),
        .m_fault (m_fault),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    // Counts cycles with err_len high
    always @(posedge clk) begin
        if (err_len) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic send_beat(input logic [FEAT_W-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input logic last_on_final);
        for (int i = 0; i < N_FEAT; i++) begin
            send_beat(w[i*FEAT_W +: FEAT_W], (i == N_FEAT-1) ? last_on_final : 1'b0);
        end
    endtask

    // Returns edges after the final beat until m_valid; 0 on timeout
    task automatic wait_mv(input int max, input bit toggle, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (m_valid) begin
                cyc = i;
                return;
            end
            if (toggle) cls_in = cls_in ^ 2'b11;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_feat",    64'(feat_inp), 64'd0);
        chk("rst_m_class", 64'(m_class), 64'd0);
        chk("rst_m_fault", 64'(m_fault), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Basic frame, m_ready high
        e0 = err_seen;
        m_ready = 1'b1;
        cls_in = 2'b10;
        send_frame(32'h87654321, 1'b1);
        wait_mv(40, 1'b0, n);
        chk("t1_latency", 64'(n), 64'(LAT));
        chk("t1_feat",    64'(feat_inp), 64'h87654321);
        chk("t1_class",   64'(m_class), 64'd2);
        chk("t1_fault",   64'(m_fault), 64'd0);
        tick();
        chk("t1_mv_drop", 64'(m_valid), 64'd0);
        chk("t1_s_ready", 64'(s_ready), 64'd1);
        chk("t1_no_err",  64'(err_seen - e0), 64'd0);

        // Back-pressure: result held until handshake
        m_ready = 1'b0;
        cls_in = 2'b10;
        send_frame(32'h87654321, 1'b1);
        wait_mv(40, 1'b0, n);
        chk("t2_latency", 64'(n), 64'(LAT));
        s_valid = 1'b1;
        s_data  = 4'hF;
        s_last  = 1'b0;
        cls_in  = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_mv",    64'(m_valid), 64'd1);
            chk("t2_hold_class", 64'(m_class), 64'd2);
            chk("t2_hold_feat",  64'(feat_inp), 64'h87654321);
            chk("t2_hold_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        tick();
        chk("t2_hs_mv",   64'(m_valid), 64'd0);
        chk("t2_hs_feat", 64'(feat_inp), 64'h87654321);
        tick();
        chk("t2_new_beat", 64'(feat_inp), 64'h8765432F);
        s_valid = 1'b0;
        do_reset();

        // Early s_last on third beat, then a clean frame
        e0 = err_seen;
        m_ready = 1'b1;
        send_beat(4'hA, 1'b0);
        send_beat(4'hB, 1'b0);
        send_beat(4'hC, 1'b1);
        chk("t3_err_pulse", 64'(err_len), 64'd1);
        chk("t3_partial",   64'(feat_inp), 64'h00000CBA);
        cls_in = 2'b01;
        send_frame(32'h89ABCDEF, 1'b1);
        chk("t3_err_clear", 64'(err_len), 64'd0);
        wait_mv(40, 1'b0, n);
        chk("t3_latency", 64'(n), 64'(LAT));
        chk("t3_feat",    64'(feat_inp), 64'h89ABCDEF);
        chk("t3_class",   64'(m_class), 64'd1);
        chk("t3_err_cnt", 64'(err_seen - e0), 64'd1);
        tick();

        // Missing s_last on final beat: flagged but still used
        e0 = err_seen;
        cls_in = 2'b11;
        send_frame(32'h76543210, 1'b0);
        chk("t4_err_pulse", 64'(err_len), 64'd1);
        wait_mv(40, 1'b0, n);
        chk("t4_latency", 64'(n), 64'(LAT));
        chk("t4_feat",    64'(feat_inp), 64'h76543210);
        chk("t4_class",   64'(m_class), 64'd3);
        chk("t4_err_cnt", 64'(err_seen - e0), 64'd1);
        tick();

        // Reset during SETTLE aborts the frame
        cls_in = 2'b01;
        send_frame(32'h11223344, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_mv",    64'(m_valid), 64'd0);
        chk("t5_rst_feat",  64'(feat_inp), 64'd0);
        chk("t5_rst_class", 64'(m_class), 64'd0);
        chk("t5_rst_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        cnt_mv = 0;
        for (int i = 0; i < SETTLE_CYC + 4; i++) begin
            tick();
            if (m_valid) cnt_mv++;
        end
        chk("t5_no_result", 64'(cnt_mv), 64'd0);
        chk("t5_ready",     64'(s_ready), 64'd1);
        cls_in = 2'b11;
        send_frame(32'h87654321, 1'b1);
        wait_mv(40, 1'b0, n);
        chk("t5_latency", 64'(n), 64'(LAT));
        chk("t5_feat",    64'(feat_inp), 64'h87654321);
        chk("t5_class",   64'(m_class), 64'd3);
        tick();

`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
        // Unstable class index: two settle windows, then faulted result
        cls_in = 2'b01;
        send_frame(32'h87654321, 1'b1);
        wait_mv(40, 1'b1, n);
        chk("ds_tog_latency", 64'(n), 64'(2*SETTLE_CYC + 2));
        chk("ds_tog_class",   64'(m_class), 64'd2);
        chk("ds_tog_fault",   64'(m_fault), 64'd1);
        tick();
        // Stable class index: single window, clean result
        cls_in = 2'b01;
        send_frame(32'h87654321, 1'b1);
        wait_mv(40, 1'b0, n);
        chk("ds_const_latency", 64'(n), 64'(SETTLE_CYC + 1));
        chk("ds_const_class",   64'(m_class), 64'd1);
        chk("ds_const_fault",   64'(m_fault), 64'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
